// File: rtl/pll_lock_mgr.sv
// PLL reset sequencer: holds the PLL in reset, qualifies LOCK with retries,
// releases downstream domain resets in a staggered order and drives phase steps.
module pll_lock_mgr #(
  parameter int NUM_OUT          = 3,
  parameter int RST_HOLD_CYC     = 64,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int LOCK_TIMEOUT_CYC = 50000,
  parameter int MAX_RETRY        = 4,
  parameter int RELEASE_GAP      = 16,
  parameter int PS_SETTLE_CYC    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pll_lock,
  input  logic               restart,
  input  logic               ps_req,
  input  logic [2:0]         ps_sel,
  input  logic               ps_dir,
  output logic               pll_rst,
  output logic               rstodiv,
  output logic [NUM_OUT-1:0] rst_out_n,
  output logic [2:0]         phase_sel,
  output logic               phase_dir,
  output logic               phase_step_n,
  output logic               ps_busy,
  output logic               ps_done,
  output logic               locked,
  output logic               fail,
  output logic [3:0]         retry_cnt,
  output logic [7:0]         loss_cnt
);
  localparam int HW = $clog2(RST_HOLD_CYC + 1);
  localparam int SW = $clog2(LOCK_STABLE_CYC + 1);
  localparam int WW = $clog2(LOCK_TIMEOUT_CYC + 1);
  localparam int GW = $clog2(RELEASE_GAP + 1);
  localparam int STAGES = PS_SETTLE_CYC + 3;
  localparam logic [HW-1:0] HOLD_LAST   = HW'(RST_HOLD_CYC - 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE_CYC - 1);
  localparam logic [WW-1:0] WAIT_LAST   = WW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [GW-1:0] GAP_LAST    = GW'(RELEASE_GAP - 1);
  localparam logic [3:0]    RETRY_LAST  = 4'(MAX_RETRY - 1);

  typedef enum logic [2:0] {S_RST, S_WAIT, S_REL, S_RUN, S_FAIL} state_t;
  typedef struct packed {
    logic [2:0] sel;
    logic       dir;
  } ps_cmd_t;

  state_t          state, state_d;
  logic            lock_s1, lock_sync, lock_prev;
  logic [HW-1:0]   hold_cnt;
  logic [SW-1:0]   stable_cnt;
  logic [WW-1:0]   wait_cnt;
  logic [GW-1:0]   gap_cnt;
  logic            loss_ev, abort, retry_inc, accept;
  logic [STAGES:0] vld_pipe;
  logic [NUM_OUT:0] rel_shift;
  ps_cmd_t         cmd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_s1   <= 1'b0;
      lock_sync <= 1'b0;
      lock_prev <= 1'b0;
    end else begin
      lock_s1   <= pll_lock;
      lock_sync <= lock_s1;
      lock_prev <= lock_sync;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_RST;
    else        state <= state_d;
  end

  always_comb begin
    state_d   = state;
    loss_ev   = 1'b0;
    abort     = 1'b0;
    retry_inc = 1'b0;
    case (state)
      S_RST:  if (hold_cnt == HOLD_LAST) state_d = S_WAIT;
      S_WAIT: begin
        if (lock_sync && stable_cnt == STABLE_LAST) state_d = S_REL;
        else if (wait_cnt == WAIT_LAST) begin
          retry_inc = 1'b1;
          state_d   = (retry_cnt == RETRY_LAST) ? S_FAIL : S_RST;
        end
      end
      S_REL, S_RUN: begin
        // two consecutive low samples filter single-cycle LOCK glitches
        loss_ev = !lock_sync && !lock_prev;
        abort   = loss_ev || restart;
        if (abort) state_d = S_RST;
        else if (state == S_REL && rst_out_n[NUM_OUT-1]) state_d = S_RUN;
      end
      S_FAIL: if (restart) state_d = S_RST;
      default: state_d = S_RST;
    endcase
  end

  assign rel_shift = {rst_out_n, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt   <= '0;
      stable_cnt <= '0;
      wait_cnt   <= '0;
      gap_cnt    <= '0;
      rst_out_n  <= '0;
      retry_cnt  <= '0;
      loss_cnt   <= '0;
    end else begin
      if (state_d != state) begin
        hold_cnt   <= '0;
        stable_cnt <= '0;
        wait_cnt   <= '0;
        gap_cnt    <= '0;
      end else begin
        case (state)
          S_RST:  hold_cnt <= hold_cnt + HW'(1);
          S_WAIT: begin
            wait_cnt   <= wait_cnt + WW'(1);
            stable_cnt <= lock_sync ? stable_cnt + SW'(1) : '0;
          end
          S_REL:  gap_cnt <= (gap_cnt == GAP_LAST) ? '0 : gap_cnt + GW'(1);
          default: ;
        endcase
      end

      if (state_d != S_REL && state_d != S_RUN)
        rst_out_n <= '0;
      else if (state == S_WAIT)
        rst_out_n <= NUM_OUT'(1);
      else if (state == S_REL && gap_cnt == GAP_LAST && !rst_out_n[NUM_OUT-1])
        rst_out_n <= rel_shift[NUM_OUT-1:0];

      if (abort || (state == S_FAIL && restart)) retry_cnt <= '0;
      else if (retry_inc)                        retry_cnt <= retry_cnt + 4'd1;

      if (loss_ev && loss_cnt != 8'hFF) loss_cnt <= loss_cnt + 8'd1;
    end
  end

  // vld_pipe[k] is high k+1 cycles after accept; the step pulse spans stages 1..2
  assign accept = (state == S_RUN) && !abort && ps_req && !ps_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      cmd      <= '0;
    end else begin
      vld_pipe <= abort ? '0 : {vld_pipe[STAGES-1:0], accept};
      if (accept) cmd <= '{sel: ps_sel, dir: ps_dir};
    end
  end

  assign phase_sel    = cmd.sel;
  assign phase_dir    = cmd.dir;
  assign phase_step_n = !(vld_pipe[1] || vld_pipe[2]);
  assign ps_busy      = |vld_pipe[STAGES-1:0];
  assign ps_done      = vld_pipe[STAGES] && !abort;
  assign pll_rst      = (state == S_RST) || (state == S_FAIL);
  assign rstodiv      = pll_rst;
  assign locked       = (state == S_RUN);
  assign fail         = (state == S_FAIL);
endmodule

// File: tb/tb_pll_lock_mgr.sv
// Directed bench for pll_lock_mgr with shortened timing parameters and a
// tag-matched expected-value scoreboard.
module tb_pll_lock_mgr;
  localparam int N = 3, H = 8, S = 32, T = 200, R = 3, G = 4, P = 8;

  logic         clk = 1'b0;
  logic         rst_n, pll_lock, restart, ps_req, ps_dir;
  logic [2:0]   ps_sel;
  logic         pll_rst, rstodiv, phase_dir, phase_step_n, ps_busy, ps_done, locked, fail;
  logic [N-1:0] rst_out_n;
  logic [2:0]   phase_sel;
  logic [3:0]   retry_cnt;
  logic [7:0]   loss_cnt;

  pll_lock_mgr #(
    .NUM_OUT(N), .RST_HOLD_CYC(H), .LOCK_STABLE_CYC(S), .LOCK_TIMEOUT_CYC(T),
    .MAX_RETRY(R), .RELEASE_GAP(G), .PS_SETTLE_CYC(P)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .restart(restart),
    .ps_req(ps_req), .ps_sel(ps_sel), .ps_dir(ps_dir),
    .pll_rst(pll_rst), .rstodiv(rstodiv), .rst_out_n(rst_out_n),
    .phase_sel(phase_sel), .phase_dir(phase_dir), .phase_step_n(phase_step_n),
    .ps_busy(ps_busy), .ps_done(ps_done), .locked(locked), .fail(fail),
    .retry_cnt(retry_cnt), .loss_cnt(loss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb_q[$];
  int n_vec = 0, n_err = 0;

  task automatic expect_v(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic observe(input string tag, input logic [31:0] obs);
    int idx;
    logic [31:0] ev;
    idx = -1;
    n_vec++;
    foreach (sb_q[i]) if (idx < 0 && sb_q[i].tag == tag) idx = i;
    if (idx < 0) begin
      n_err++;
      $error("FAIL %s observed=%0h expected=<none queued>", tag, obs);
    end else begin
      ev = sb_q[idx].val;
      sb_q.delete(idx);
      assert (obs === ev) else begin
        n_err++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, ev);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] ev);
    expect_v(tag, ev);
    observe(tag, obs);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_locked(input string tag, input int maxc);
    int c;
    c = 0;
    while (!locked && c < maxc) begin
      tick(1);
      c++;
    end
    chk(tag, 32'(locked), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows, done_at, seen;
    rst_n = 1'b0; pll_lock = 1'b0; restart = 1'b0;
    ps_req = 1'b0; ps_sel = 3'd0; ps_dir = 1'b0;
    tick(3);
    chk("rst_pll_rst",   32'(pll_rst), 1);
    chk("rst_rstodiv",   32'(rstodiv), 1);
    chk("rst_rst_out_n", 32'(rst_out_n), 0);
    chk("rst_phase_sel", 32'(phase_sel), 0);
    chk("rst_phase_dir", 32'(phase_dir), 0);
    chk("rst_step_n",    32'(phase_step_n), 1);
    chk("rst_busy",      32'(ps_busy), 0);
    chk("rst_done",      32'(ps_done), 0);
    chk("rst_locked",    32'(locked), 0);
    chk("rst_fail",      32'(fail), 0);
    chk("rst_retry",     32'(retry_cnt), 0);
    chk("rst_loss",      32'(loss_cnt), 0);

    // clean lock: LOCK rises as pll_rst falls
    rst_n = 1'b1;
    tick(H - 1); chk("hold_pll_rst", 32'(pll_rst), 1);
    tick(1);     chk("pll_rst_fall", 32'(pll_rst), 0);
    chk("rstodiv_follow", 32'(rstodiv), 0);
    pll_lock = 1'b1;
    tick(S + 1); chk("pre_release", 32'(rst_out_n), 0);
    tick(1);     chk("rel_001", 32'(rst_out_n), 3'b001);
    tick(G - 1); chk("rel_001_hold", 32'(rst_out_n), 3'b001);
    tick(1);     chk("rel_011", 32'(rst_out_n), 3'b011);
    tick(G);     chk("rel_111", 32'(rst_out_n), 3'b111);
    chk("locked_pre", 32'(locked), 0);
    tick(1);     chk("locked_run", 32'(locked), 1);
    chk("retry_clean", 32'(retry_cnt), 0);

    // phase step with a second request at t+3 that must be dropped
    ps_sel = 3'd2; ps_dir = 1'b1; ps_req = 1'b1;
    expect_v("ps_done_at", 12);
    expect_v("ps_step_low", 2);
    lows = 0; done_at = 0;
    for (int k = 1; k <= 14; k++) begin
      tick(1);
      if (k == 1) begin
        ps_req = 1'b0;
        chk("ps_sel_t1", 32'(phase_sel), 2);
        chk("ps_dir_t1", 32'(phase_dir), 1);
        chk("ps_busy_t1", 32'(ps_busy), 1);
      end
      if (k == 3) begin ps_req = 1'b1; ps_sel = 3'd5; ps_dir = 1'b0; end
      if (k == 4) ps_req = 1'b0;
      if (!phase_step_n) lows++;
      if (ps_done && done_at == 0) done_at = k;
    end
    observe("ps_done_at", 32'(done_at));
    observe("ps_step_low", 32'(lows));
    chk("ps_second_dropped", 32'(phase_sel), 2);
    chk("ps_busy_idle", 32'(ps_busy), 0);

    // lock loss: 1-cycle drop ignored, 3-cycle drop re-sequences
    pll_lock = 1'b0; tick(1); pll_lock = 1'b1;
    tick(4);
    chk("glitch_locked", 32'(locked), 1);
    chk("glitch_loss", 32'(loss_cnt), 0);
    pll_lock = 1'b0; tick(3); pll_lock = 1'b1;
    chk("loss_not_yet", 32'(rst_out_n), 3'b111);
    tick(1);
    chk("loss_rst_out", 32'(rst_out_n), 0);
    chk("loss_cnt_1", 32'(loss_cnt), 1);
    chk("loss_pll_rst", 32'(pll_rst), 1);
    chk("loss_locked", 32'(locked), 0);
    wait_locked("relock1", 200);
    chk("relock1_rst_out", 32'(rst_out_n), 3'b111);
    chk("relock1_retry", 32'(retry_cnt), 0);

    // abort a phase step with a loss detected at t+2
    pll_lock = 1'b0; tick(1);
    ps_sel = 3'd1; ps_dir = 1'b0; ps_req = 1'b1;
    tick(1); ps_req = 1'b0;
    chk("abort_busy_t1", 32'(ps_busy), 1);
    tick(1);
    chk("abort_step_t2", 32'(phase_step_n), 0);
    tick(1);
    chk("abort_step_t3", 32'(phase_step_n), 1);
    chk("abort_busy_t3", 32'(ps_busy), 0);
    chk("abort_rst_out", 32'(rst_out_n), 0);
    chk("abort_loss", 32'(loss_cnt), 2);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      if (ps_done) seen = 1;
    end
    chk("abort_no_done", 32'(seen), 0);

    // LOCK stays low: timeouts count up to FAIL
    for (int k = 1; k <= R; k++) begin
      tick((k == 1) ? (H + T - 1 - 12) : (H + T - 1));
      chk("to_retry_before", 32'(retry_cnt), 32'(k - 1));
      chk("to_pll_rst_low", 32'(pll_rst), 0);
      tick(1);
      chk("to_retry_after", 32'(retry_cnt), 32'(k));
      chk("to_pll_rst_high", 32'(pll_rst), 1);
      chk("to_fail", 32'(fail), (k == R) ? 32'd1 : 32'd0);
    end
    tick(20);
    chk("fail_sticky", 32'(fail), 1);
    chk("fail_rst_out", 32'(rst_out_n), 0);
    restart = 1'b1; tick(1); restart = 1'b0;
    chk("restart_fail", 32'(fail), 0);
    chk("restart_retry", 32'(retry_cnt), 0);
    chk("restart_pll_rst", 32'(pll_rst), 1);

    // relock, then restart from RUN keeps loss_cnt
    pll_lock = 1'b1;
    wait_locked("relock2", 300);
    restart = 1'b1; tick(1); restart = 1'b0;
    chk("run_restart_rst_out", 32'(rst_out_n), 0);
    chk("run_restart_loss", 32'(loss_cnt), 2);
    chk("run_restart_pll_rst", 32'(pll_rst), 1);
    wait_locked("relock3", 300);

    // asynchronous reset in the middle of a phase step
    ps_sel = 3'd3; ps_req = 1'b1; tick(1); ps_req = 1'b0; tick(1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out", 32'(rst_out_n), 0);
    chk("async_loss", 32'(loss_cnt), 0);
    chk("async_busy", 32'(ps_busy), 0);
    chk("async_step_n", 32'(phase_step_n), 1);
    chk("async_pll_rst", 32'(pll_rst), 1);
    chk("async_phase_sel", 32'(phase_sel), 0);

    // chattering LOCK: 20-cycle high pulses never qualify
    @(negedge clk);
    pll_lock = 1'b0;
    tick(2);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pll_lock = ~pll_lock;
      tick(20);
      chk("chatter_hold", 32'(rst_out_n), 0);
    end
    pll_lock = 1'b1;
    tick(S + 1); chk("chatter_pre_rel", 32'(rst_out_n), 0);
    tick(1);     chk("chatter_rel", 32'(rst_out_n), 3'b001);
    chk("chatter_retry", 32'(retry_cnt), 0);
    wait_locked("chatter_locked", 50);

    if (sb_q.size() != 0) begin
      n_err += sb_q.size();
      $error("FAIL sb_leftover observed=%0d expected=0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pll_lock_mgr.md
# pll_lock_mgr

Reset sequencer and phase-step controller for the on-chip PLL (GTP_PLL_E3).
- Holds the PLL in reset, then qualifies LOCK and retries on lock timeout.
- Releases up to NUM_OUT downstream clock-domain resets in a staggered order.
- Re-sequences automatically on loss of lock.
- Drives the PLL dynamic phase-step pins through a request/done handshake.
- Runs on the 50 MHz board clock that also feeds the PLL CLKIN1, and sits between the PLL wrapper and the user logic (UART and other labs).

## Interface
Parameters:
- NUM_OUT, 3: number of downstream domain resets (1..5).
- RST_HOLD_CYC, 64: cycles pll_rst is held high per attempt (>=2).
- LOCK_STABLE_CYC, 1024: consecutive synchronised-lock-high cycles needed to qualify lock.
- LOCK_TIMEOUT_CYC, 50000: cycles allowed in WAIT_LOCK before a retry.
- MAX_RETRY, 4: attempts before entering FAIL (1..15).
- RELEASE_GAP, 16: cycles between successive domain reset releases (>=1).
- PS_SETTLE_CYC, 8: busy cycles after a phase-step pulse (>=1).

Ports:
- clk  in  1  board clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- pll_lock  in  1  PLL LOCK; asynchronous, double-flop synchronised internally.
- restart  in  1  single-cycle pulse: leave FAIL, or restart from RUN.
- ps_req  in  1  single-cycle phase-step request.
- ps_sel  in  3  output index to step; captured on ps_req.
- ps_dir  in  1  step direction (1 = advance); captured on ps_req.
- pll_rst  out  1  to PLL RST.
- rstodiv  out  1  to PLL RSTODIV; always equal to pll_rst.
- rst_out_n  out  NUM_OUT  per-domain active-low resets.
- phase_sel  out  3  to PLL PHASE_SEL.
- phase_dir  out  1  to PLL PHASE_DIR.
- phase_step_n  out  1  to PLL PHASE_STEP_N, active low.
- ps_busy  out  1  phase step in progress.
- ps_done  out  1  one-cycle pulse when the step completes.
- locked  out  1  high only in RUN.
- fail  out  1  high only in FAIL.
- retry_cnt  out  4  attempts used in the current sequence.
- loss_cnt  out  8  lock-loss events since reset; saturates at 255.

## Operation
- Reset values: pll_rst=1, rstodiv=1, rst_out_n=0, phase_sel=0, phase_dir=0, phase_step_n=1, ps_busy=0, ps_done=0, locked=0, fail=0, retry_cnt=0, loss_cnt=0. State is RST.
- RST: pll_rst=1 for RST_HOLD_CYC cycles, then go to WAIT_LOCK. The wait and stable counters clear on entry.
- WAIT_LOCK: pll_rst=0. The stable counter increments while lock_sync=1 and clears when lock_sync=0.
  - Stable counter reaches LOCK_STABLE_CYC: go to RELEASE.
  - Otherwise, wait counter reaches LOCK_TIMEOUT_CYC: retry_cnt++. If retry_cnt then equals MAX_RETRY go to FAIL, else go to RST.
- RELEASE: rst_out_n[0] rises on entry. rst_out_n[i] rises RELEASE_GAP cycles after rst_out_n[i-1]. After bit NUM_OUT-1 rises, go to RUN. Once released, a bit stays high until a lock loss or restart.
- RUN: locked=1; phase steps are accepted.
- Lock loss: lock_sync=0 for 2 consecutive cycles in RELEASE or RUN. In the same cycle:
  - all rst_out_n go to 0;
  - loss_cnt++ (saturating);
  - retry_cnt clears;
  - any phase step is aborted (phase_step_n=1, ps_busy=0, no ps_done);
  - go to RST.
- FAIL: fail=1, pll_rst=1, rst_out_n=0. Only restart leaves FAIL: retry_cnt clears, go to RST.
- restart in RUN or RELEASE: treated as a lock loss, but loss_cnt does not increment. restart in RST or WAIT_LOCK is ignored.
- Phase step: ps_req is accepted only when RUN && !ps_busy; otherwise it is dropped silently.
  - On accept, phase_sel/phase_dir load and ps_busy=1.
  - ps_sel >= NUM_OUT is still accepted and passed through unchanged.
- Counters are sized $clog2(param+1). Every compare is == against the parameter; nothing wraps.

## Timing
- lock_sync lags pll_lock by 2 clk.
- Minimum time from rst_n release to locked:
  - RST_HOLD_CYC + 2 (sync) + LOCK_STABLE_CYC + (NUM_OUT-1)*RELEASE_GAP + 1 cycles;
  - locked rises in the cycle after the last rst_out_n release.
- Phase-step cycle sequence, accept at cycle t:
  - t+1: phase_sel/phase_dir valid, ps_busy=1.
  - t+2, t+3: phase_step_n=0.
  - t+4 through t+3+PS_SETTLE_CYC: settle.
  - t+4+PS_SETTLE_CYC: ps_done=1 for one cycle, ps_busy=0. A new ps_req is accepted in this same cycle.
- Lock loss or restart takes priority over a same-cycle ps_req.
- Asynchronous rst_n mid-operation restores all reset values immediately, with no glitch on rst_out_n high.

## Test plan
- Clean lock: pll_lock rises 100 cycles after reset (defaults). Required:
  - pll_rst falls at cycle 64;
  - rst_out_n becomes 3'b001, 3'b011, 3'b111 at 16-cycle spacing;
  - locked=1; retry_cnt=0.
- Chattering lock: toggle pll_lock every 500 cycles for 5000 cycles, then hold high. Required:
  - no rst_out_n release until 1024 consecutive synchronised high cycles;
  - retry_cnt=0.
- Timeout and fail: pll_lock held 0. Required:
  - 4 attempts of 64 + 50000 cycles each, with retry_cnt counting 1..4;
  - fail=1, pll_rst=1;
  - a restart pulse clears fail and retry_cnt and reasserts pll_rst.
- Lock loss in RUN: drop pll_lock 1 cycle, then drop it 3 cycles. Required:
  - the 1-cycle drop is ignored;
  - the 3-cycle drop gives rst_out_n=0 within 4 cycles, loss_cnt=1, state RST, full re-sequence.
- Phase step: ps_req with ps_sel=2, ps_dir=1 in RUN, plus a second ps_req at t+3. Required:
  - phase_step_n low exactly 2 cycles;
  - ps_done at t+12;
  - the second request is dropped.
- Abort: lock loss at t+2 of a phase step. Required:
  - phase_step_n=1 in the next cycle;
  - no ps_done; ps_busy=0.
